// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame buffer arbiter constants and FSM state type
package fb_pkg;

   // RAM geometry: 3-bit {B,G,R} pixels, 17-bit word address
   localparam int ADDR_W  = 17;
   localparam int DATA_W  = 3;

   // Active 256x240 window inside the 640x480 raster
   localparam int H_START = 192;
   localparam int H_END   = 447;
   localparam int V_START = 120;
   localparam int V_END   = 359;

   localparam int FB_WORDS = (H_END - H_START + 1) * (V_END - V_START + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_t;

endpackage

// File: rtl/fb_window_cmp.sv
// rtl/fb_window_cmp.sv - active-window and frame-origin decode of the raster position
module fb_window_cmp #(
   parameter int H_START = fb_pkg::H_START,
   parameter int H_END   = fb_pkg::H_END,
   parameter int V_START = fb_pkg::V_START,
   parameter int V_END   = fb_pkg::V_END
) (
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic        in_window,
   output logic        frame_origin
);

   localparam logic [10:0] HS = 11'(H_START);
   localparam logic [10:0] HE = 11'(H_END);
   localparam logic [9:0]  VS = 10'(V_START);
   localparam logic [9:0]  VE = 10'(V_END);

   // Both bounds are inclusive; origin is the first pixel of the raster
   always_comb begin
      in_window    = (hcount >= HS) && (hcount <= HE) && (vcount >= VS) && (vcount <= VE);
      frame_origin = (hcount == 11'd0) && (vcount == 10'd0);
   end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame RAM port arbiter: display fetch, clear engine, pixel writer
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W   = fb_pkg::ADDR_W,
   parameter int DATA_W   = fb_pkg::DATA_W,
   parameter int H_START  = fb_pkg::H_START,
   parameter int H_END    = fb_pkg::H_END,
   parameter int V_START  = fb_pkg::V_START,
   parameter int V_END    = fb_pkg::V_END,
   parameter int FB_WORDS = (H_END - H_START + 1) * (V_END - V_START + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pix_en,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);
   localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_WORDS);

   fb_state_t         state;
   fb_state_t         stateNext;
   logic [ADDR_W-1:0] fetchPtr;
   logic [ADDR_W-1:0] clearPtr;
   logic [ADDR_W-1:0] lastAddr;
   logic [DATA_W-1:0] clearColorReg;
   logic              inWindow;
   logic              frameOrigin;
   logic              fetch;
   logic              clearWrite;
   logic              clearLast;
   logic              wrAccept;
   logic              wrInRange;
   logic              fetchDly;

   fb_window_cmp #(
      .H_START (H_START),
      .H_END   (H_END),
      .V_START (V_START),
      .V_END   (V_END)
   ) uWindow (
      .hcount       (hcount),
      .vcount       (vcount),
      .in_window    (inWindow),
      .frame_origin (frameOrigin)
   );

   assign fetch      = pix_en & inWindow;
   assign clearWrite = (state == CLEAR) & ~fetch;
   assign clearLast  = clearWrite & (clearPtr == LAST_WORD);
   assign wrAccept   = wr_valid & wr_ready;
   assign wrInRange  = {1'b0, wr_addr} < FB_LIMIT;
   assign clear_busy = (state == CLEAR);

   // Port mux: display fetch first, then clear, then writer; all grants dead while in reset
   always_comb begin
      wr_ready  = 1'b0;
      ram_addr  = lastAddr;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (reset) begin
         ram_addr = '0;
      end else begin
         wr_ready = ~fetch & (state == IDLE);
         if (fetch) begin
            ram_addr = fetchPtr;
         end else if (state == CLEAR) begin
            ram_addr  = clearPtr;
            ram_we    = 1'b1;
            ram_wdata = clearColorReg;
         end else if (wr_valid) begin
            ram_addr  = wr_addr;
            ram_we    = wrInRange;
            ram_wdata = wr_data;
         end
      end
   end

   // Clear FSM next state; a clear request during CLEAR has no effect
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (clear_req) stateNext = CLEAR;
         CLEAR:   if (clearLast) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Clear FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Fetch/clear pointers, latched clear colour and the held idle address
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetchPtr      <= '0;
         clearPtr      <= '0;
         clearColorReg <= '0;
         lastAddr      <= '0;
      end else begin
         // Frame origin wins over any increment so the pointer is locked to the raster
         if (pix_en & frameOrigin)  fetchPtr <= '0;
         else if (fetch)            fetchPtr <= (fetchPtr == LAST_WORD) ? '0 : fetchPtr + 1'b1;

         if ((state == IDLE) & clear_req) begin
            clearPtr      <= '0;
            clearColorReg <= clear_color;
         end else if (clearWrite) begin
            clearPtr <= clearPtr + 1'b1;
         end

         if (fetch | clearWrite | wrAccept) lastAddr <= ram_addr;
      end
   end

   // Status pulses and display pixel register (RAM data arrives one cycle after the fetch)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_err     <= 1'b0;
         clear_done <= 1'b0;
         fetchDly   <= 1'b0;
         disp_data  <= '0;
      end else begin
         wr_err     <= wrAccept & ~wrInRange;
         clear_done <= clearLast;
         fetchDly   <= fetch;
         if (fetchDly)                 disp_data <= ram_rdata;
         else if (pix_en & ~inWindow)  disp_data <= '0;
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter on a reduced raster
module tb_fb_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 3;
   localparam int HS     = 8;
   localparam int HE     = 23;
   localparam int VS     = 3;
   localparam int VE     = 10;
   localparam int W      = HE - HS + 1;
   localparam int FB     = W * (VE - VS + 1);
   localparam int HT     = 32;
   localparam int VT     = 14;

   logic              clock = 1'b0;
   logic              reset;
   logic              pix_en;
   logic [10:0]       hcount;
   logic [9:0]        vcount;
   logic [DATA_W-1:0] disp_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_err;
   logic              clear_req;
   logic [DATA_W-1:0] clear_color;
   logic              clear_busy;
   logic              clear_done;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              preload;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int  hPos, vPos;
   bit  phase, runTiming, synced, modelClear, errPend, donePend;
   int  freePtr, clearIdx, lastAddr, fetchCount, frameFetches, doneSeen;
   logic [DATA_W-1:0] clrColor, dispExp;

   fb_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W),
      .H_START (HS), .H_END (HE), .V_START (VS), .V_END (VE)
   ) dut (
      .clock (clock), .reset (reset), .pix_en (pix_en), .hcount (hcount), .vcount (vcount),
      .disp_data (disp_data), .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr),
      .wr_data (wr_data), .wr_err (wr_err), .clear_req (clear_req), .clear_color (clear_color),
      .clear_busy (clear_busy), .clear_done (clear_done), .ram_addr (ram_addr), .ram_we (ram_we),
      .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
   );

   always #5 clock = ~clock;

   // single-port frame RAM with one-cycle read latency
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i % 8);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_disp"}, disp_data, 0);
      check({tag, "_ready"}, wr_ready, 0);
      check({tag, "_err"}, wr_err, 0);
      check({tag, "_busy"}, clear_busy, 0);
      check({tag, "_done"}, clear_done, 0);
      check({tag, "_addr"}, ram_addr, 0);
      check({tag, "_we"}, ram_we, 0);
      check({tag, "_wdata"}, ram_wdata, 0);
   endtask

   task automatic modelReset();
      synced = 0; freePtr = 0; modelClear = 0; lastAddr = 0;
      errPend = 0; donePend = 0; dispExp = '0; fetchCount = 0;
   endtask

   // one clock: drive raster, check outputs at the falling edge, advance the model after the edge
   task automatic tick();
      bit inWin, fetchE, acceptE, inRange, clrWr;
      int h, v, addrE;
      logic [DATA_W-1:0] newDisp;
      pix_en = 1'b0;
      if (runTiming) begin
         phase = ~phase;
         if (phase) begin
            pix_en = 1'b1;
            hcount = 11'(hPos);
            vcount = 10'(vPos);
         end
      end
      @(negedge clock);
      h       = int'(hcount);
      v       = int'(vcount);
      inWin   = (h >= HS) && (h <= HE) && (v >= VS) && (v <= VE);
      fetchE  = pix_en && inWin;
      addrE   = synced ? (v - VS) * W + (h - HS) : freePtr;
      clrWr   = !fetchE && modelClear;
      acceptE = !fetchE && !modelClear && wr_valid;
      inRange = int'(wr_addr) < FB;
      if (pix_en) check("disp_data", disp_data, dispExp);
      check("clear_busy", clear_busy, modelClear);
      check("wr_err", wr_err, errPend);
      check("clear_done", clear_done, donePend);
      if (clear_done) doneSeen++;
      if (fetchE) begin
         check("fetch_addr", ram_addr, addrE);
         check("fetch_we", ram_we, 0);
         check("fetch_ready", wr_ready, 0);
         fetchCount++;
      end else if (clrWr) begin
         check("clr_addr", ram_addr, clearIdx);
         check("clr_we", ram_we, 1);
         check("clr_wdata", ram_wdata, clrColor);
         check("clr_ready", wr_ready, 0);
      end else if (acceptE) begin
         check("wr_ready", wr_ready, 1);
         check("wr_addr", ram_addr, wr_addr);
         check("wr_we", ram_we, inRange);
         if (inRange) check("wr_wdata", ram_wdata, wr_data);
      end else begin
         check("idle_we", ram_we, 0);
         check("idle_addr", ram_addr, lastAddr);
         check("idle_ready", wr_ready, 1);
      end
      newDisp = fetchE ? mem[addrE] : '0;
      @(posedge clock);
      #1;
      errPend  = acceptE && !inRange;
      donePend = 0;
      if (pix_en) begin
         dispExp = newDisp;
         if (h == 0 && v == 0) begin
            synced = 1; frameFetches = fetchCount; fetchCount = 0;
         end
         hPos++;
         if (hPos == HT) begin hPos = 0; vPos = (vPos + 1) % VT; end
      end
      if (fetchE) begin lastAddr = addrE; freePtr = (freePtr + 1) % FB; end
      if (clrWr) begin
         lastAddr = clearIdx;
         if (clearIdx == FB - 1) begin modelClear = 0; donePend = 1; end
         else clearIdx++;
      end else if (!modelClear && clear_req) begin
         modelClear = 1; clearIdx = 0; clrColor = clear_color;
      end
      if (acceptE) begin lastAddr = int'(wr_addr); wr_valid = 1'b0; end
      clear_req = 1'b0;
   endtask

   // advance until the next tick strobes pixel (h,v)
   task automatic runUntil(input int h, input int v);
      int guard = 0;
      while (!(hPos == h && vPos == v && phase == 1'b0) && guard < 4 * HT * VT) begin
         tick();
         guard++;
      end
      check("run_until_bound", guard < 4 * HT * VT, 1);
   endtask

   task automatic nextOrigin();
      runUntil(0, 0);
      tick();
   endtask

   task automatic midReset(input string tag);
      pix_en = 1'b1;
      hcount = 11'(HS + 3);
      vcount = 10'(VS + 2);
      #2 reset = 1'b1;
      #1 checkAllZero(tag);
      pix_en = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      modelReset();
   endtask

   initial begin
      reset = 1'b1; preload = 1'b1; pix_en = 1'b0; hcount = '0; vcount = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0; clear_color = '0;
      runTiming = 0; phase = 0; hPos = 0; vPos = 0; doneSeen = 0; frameFetches = 0;
      clearIdx = 0; clrColor = '0;
      modelReset();
      @(posedge clock);
      #1 preload = 1'b0;
      @(posedge clock);
      #1 checkAllZero("reset");
      reset = 1'b0;
      runTiming = 1;

      // one clean frame from the origin, RAM holds addr%8
      nextOrigin();
      nextOrigin();
      check("frame_fetches", frameFetches, FB);

      // writer held across active video: blocked on the fetch, lands on the free cycle
      runUntil(HS + 2, VS + 1);
      wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 3'd3;
      tick();
      check("wr_pending_after_fetch", wr_valid, 1);
      tick();
      check("wr_taken_on_free", wr_valid, 0);
      nextOrigin();
      runUntil(HS + 6, VS);
      check("pix5_shows_3", disp_data, 3);
      check("mem5", mem[5], 3);

      // out-of-range write: accepted, dropped, one error pulse
      runUntil(HS + 1, VS + 4);
      tick();
      wr_valid = 1'b1; wr_addr = 8'(FB); wr_data = 3'd7;
      tick();
      check("oor_accepted", wr_valid, 0);
      check("oor_err_pulse", wr_err, 1);
      tick();
      check("oor_err_cleared", wr_err, 0);
      check("oor_ram_unchanged", mem[FB], 3'(FB % 8));

      // randomized writer traffic including out-of-range addresses
      for (int n = 0; n < 400; n++) begin
         if (!wr_valid && $urandom_range(0, 2) == 0) begin
            wr_valid = 1'b1;
            wr_addr  = 8'($urandom_range(0, FB + 20));
            wr_data  = 3'($urandom);
         end
         tick();
      end
      wr_valid = 1'b0;

      // clear mid-frame together with an accepted write, then a second ignored request
      doneSeen = 0;
      runUntil(HS + 2, VS + 3);
      tick();
      wr_valid = 1'b1; wr_addr = 8'd9; wr_data = 3'd2;
      clear_req = 1'b1; clear_color = 3'b101;
      tick();
      check("clear_busy_start", clear_busy, 1);
      repeat (10) tick();
      clear_req = 1'b1; clear_color = 3'd2;
      tick();
      for (int g = 0; g < 4000 && (modelClear || donePend); g++) tick();
      check("clear_finished", modelClear || donePend, 0);
      tick();
      check("clear_done_count", doneSeen, 1);
      for (int i = 0; i < FB; i++) check("cleared_word", mem[i], 3'b101);
      nextOrigin();
      nextOrigin();
      check("frame_fetches_after_clear", frameFetches, FB);

      // reset during a clear and mid-line
      runUntil(HS + 4, VS + 1);
      clear_req = 1'b1; clear_color = 3'd6;
      tick();
      repeat (20) tick();
      check("busy_before_reset", clear_busy, 1);
      midReset("midreset");
      tick();
      check("post_reset_busy", clear_busy, 0);
      check("partial_first", mem[0], 3'd6);
      check("partial_last", mem[FB-1], 3'b101);
      nextOrigin();
      nextOrigin();
      check("frame_fetches_after_reset", frameFetches, FB);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
